dmem_mmio_bus: RTL and testbench

- Data-side memory system attached to the single-cycle RV32I core's data port. Consumes `data_addr`, `write_data` and `mem_write`, and returns `read_data` in the same cycle.
- Decodes each access to one of: word-addressed data RAM, GPIO output register, free-running cycle counter, or an 8N1 UART transmitter with its own bit-timing state machine.
- This is the stage that turns the core's store/load traffic into RAM state and observable I/O.

---
 rtl/dmem_mmio_bus_if.sv | 22 ++
 rtl/dmem_mmio_bus.sv | 189 ++++++++++++++++++
 tb/tb_dmem_mmio_bus.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_mmio_bus_if.sv
// Data-port bundle between the single-cycle core and its memory/MMIO system.
// Loads return combinationally on read_data within the same cycle.
interface dmem_mmio_bus_if;
  logic [31:0] data_addr;
  logic [31:0] write_data;
  logic        mem_write;
  logic [31:0] read_data;

  modport master (
    output data_addr,
    output write_data,
    output mem_write,
    input  read_data
  );

  modport slave (
    input  data_addr,
    input  write_data,
    input  mem_write,
    output read_data
  );
endinterface

// File: rtl/dmem_mmio_bus.sv
// Data-side memory system: word RAM, GPIO register, cycle counter and an
// 8N1 UART transmitter, all decoded from the core's data port.
module dmem_mmio_bus #(
  parameter int DMEM_WORDS   = 256,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  dmem_mmio_bus_if.slave        bus,
  output logic [7:0]            gpio_out,
  output logic                  uart_tx
);

  localparam int IDX_W  = $clog2(DMEM_WORDS);
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  localparam logic [31:0] GPIO_ADDR   = 32'h1000_0000;
  localparam logic [31:0] TXDATA_ADDR = 32'h1000_0004;
  localparam logic [31:0] STATUS_ADDR = 32'h1000_0008;
  localparam logic [31:0] CYCLE_ADDR  = 32'h1000_000C;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  logic [31:0]       mem_r [DMEM_WORDS];
  logic [7:0]        gpio_r;
  logic [31:0]       cycle_r;

  uart_state_t       state_r, state_next_s;
  logic [BAUD_W-1:0] baud_r, baud_next_s;
  logic [2:0]        bit_r, bit_next_s;
  logic [7:0]        shift_r, shift_next_s;
  logic              tx_r, tx_next_s;
  logic              busy_s;

  logic [31:0]       word_addr_s;
  logic [IDX_W-1:0]  idx_s;
  logic              ram_sel_s;
  logic              ram_we_s;
  logic              gpio_we_s;
  logic              tx_we_s;
  logic [31:0]       rd_s;
  logic              unused_addr_s;

  assign unused_addr_s = ^bus.data_addr[1:0];

  // Address decode and per-target write strobes; one store hits one target
  always_comb begin
    word_addr_s = {bus.data_addr[31:2], 2'b00};
    idx_s       = bus.data_addr[IDX_W+1:2];
    ram_sel_s   = (bus.data_addr[31:IDX_W+2] == '0);
    ram_we_s    = bus.mem_write && ram_sel_s;
    gpio_we_s   = bus.mem_write && (word_addr_s == GPIO_ADDR);
    tx_we_s     = bus.mem_write && (word_addr_s == TXDATA_ADDR);
  end

  // Combinational load mux over pre-edge register and RAM contents
  always_comb begin
    rd_s = 32'd0;
    case (word_addr_s)
      GPIO_ADDR:   rd_s = {24'd0, gpio_r};
      STATUS_ADDR: rd_s = {31'd0, busy_s};
      CYCLE_ADDR:  rd_s = cycle_r;
      default: begin
        if (ram_sel_s) begin
          rd_s = mem_r[idx_s];
        end else begin
          rd_s = 32'd0;
        end
      end
    endcase
  end

  assign bus.read_data = rd_s;

  // Data RAM write port; contents intentionally survive reset
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      mem_r[idx_s] <= bus.write_data;
    end
  end

  // GPIO output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpio_r <= 8'd0;
    end else if (gpio_we_s) begin
      gpio_r <= bus.write_data[7:0];
    end
  end

  // Free-running cycle counter, wraps naturally at 32 bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_r <= 32'd0;
    end else begin
      cycle_r <= cycle_r + 32'd1;
    end
  end

  assign busy_s = (state_r != ST_IDLE);

  // UART next-state logic; the line level is computed from the next state so it is registered
  always_comb begin
    state_next_s = state_r;
    baud_next_s  = baud_r;
    bit_next_s   = bit_r;
    shift_next_s = shift_r;
    tx_next_s    = 1'b1;
    case (state_r)
      ST_IDLE: begin
        if (tx_we_s) begin
          shift_next_s = bus.write_data[7:0];
          baud_next_s  = '0;
          state_next_s = ST_START;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_r == BAUD_LAST) begin
          baud_next_s  = '0;
          bit_next_s   = 3'd0;
          state_next_s = ST_DATA;
        end else begin
          baud_next_s  = baud_r + {{(BAUD_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DATA: begin
        if (baud_r == BAUD_LAST) begin
          baud_next_s  = '0;
          shift_next_s = {1'b0, shift_r[7:1]};
          if (bit_r == 3'd7) begin
            state_next_s = ST_STOP;
          end else begin
            bit_next_s   = bit_r + 3'd1;
          end
        end else begin
          baud_next_s  = baud_r + {{(BAUD_W-1){1'b0}}, 1'b1};
        end
      end
      ST_STOP: begin
        if (baud_r == BAUD_LAST) begin
          baud_next_s  = '0;
          state_next_s = ST_IDLE;
        end else begin
          baud_next_s  = baud_r + {{(BAUD_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        baud_next_s  = '0;
        bit_next_s   = 3'd0;
      end
    endcase

    case (state_next_s)
      ST_START: tx_next_s = 1'b0;
      ST_DATA:  tx_next_s = shift_next_s[0];
      default:  tx_next_s = 1'b1;
    endcase
  end

  // UART state, counters, shift register and line register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      baud_r  <= '0;
      bit_r   <= 3'd0;
      shift_r <= 8'd0;
      tx_r    <= 1'b1;
    end else begin
      state_r <= state_next_s;
      baud_r  <= baud_next_s;
      bit_r   <= bit_next_s;
      shift_r <= shift_next_s;
      tx_r    <= tx_next_s;
    end
  end

  assign gpio_out = gpio_r;
  assign uart_tx  = tx_r;

endmodule

// File: tb/tb_dmem_mmio_bus.sv
// Randomised and directed bench for dmem_mmio_bus against a cycle-indexed
// reference model (RAM array, GPIO byte, frame start time and payload).
module tb_dmem_mmio_bus;
  localparam int WORDS = 256;
  localparam int CPB   = 4;
  localparam logic [31:0] A_GPIO   = 32'h1000_0000;
  localparam logic [31:0] A_TX     = 32'h1000_0004;
  localparam logic [31:0] A_STATUS = 32'h1000_0008;
  localparam logic [31:0] A_CYCLE  = 32'h1000_000C;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] gpio_out;
  logic       uart_tx;

  dmem_mmio_bus_if bus ();

  dmem_mmio_bus #(.DMEM_WORDS(WORDS), .CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .gpio_out (gpio_out),
    .uart_tx  (uart_tx)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] m_mem [WORDS];
  logic [7:0]  m_gpio;
  logic [31:0] cyc;
  bit          f_on;
  logic [31:0] f_start;
  logic [7:0]  f_byte;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_busy();
    return f_on && ((cyc - f_start) < 32'(10 * CPB));
  endfunction

  // A frame is start bit, 8 data bits LSB first, stop bit, each CPB cycles long
  function automatic logic exp_tx();
    int k;
    if (!m_busy()) return 1'b1;
    k = int'((cyc - f_start) / 32'(CPB));
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return f_byte[k-1];
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (w[31:10] == 22'd0) return m_mem[w[9:2]];
    if (w == A_GPIO)       return {24'd0, m_gpio};
    if (w == A_STATUS)     return {31'd0, m_busy()};
    if (w == A_CYCLE)      return cyc;
    return 32'd0;
  endfunction

  task automatic model_reset();
    cyc    = 32'd0;
    m_gpio = 8'd0;
    f_on   = 1'b0;
  endtask

  // One clock: update the model from the inputs seen at the edge, then compare
  task automatic tick();
    logic [31:0] w;
    if (bus.mem_write) begin
      w = {bus.data_addr[31:2], 2'b00};
      if (w[31:10] == 22'd0) begin
        m_mem[w[9:2]] = bus.write_data;
      end else if (w == A_GPIO) begin
        m_gpio = bus.write_data[7:0];
      end else if (w == A_TX && !m_busy()) begin
        f_on    = 1'b1;
        f_start = cyc + 32'd1;
        f_byte  = bus.write_data[7:0];
      end
    end
    @(posedge clk);
    cyc = cyc + 32'd1;
    @(negedge clk);
    check_eq("uart_tx", {31'd0, uart_tx}, {31'd0, exp_tx()});
    check_eq("gpio", {24'd0, gpio_out}, {24'd0, m_gpio});
    check_eq("read", bus.read_data, m_read(bus.data_addr));
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.data_addr  = a;
    bus.write_data = d;
    bus.mem_write  = 1'b1;
    tick();
    bus.mem_write  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    bus.data_addr = a;
    bus.mem_write = 1'b0;
    tick();
  endtask

  initial begin
    logic [31:0] a;
    int op;
    reset          = 1'b1;
    bus.data_addr  = A_TX;
    bus.write_data = 32'd0;
    bus.mem_write  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Reset state and cycle count after five idle cycles
    repeat (5) tick();
    check_eq("rst_gpio", {24'd0, gpio_out}, 32'h0000_0000);
    check_eq("rst_tx", {31'd0, uart_tx}, 32'd1);
    bus.data_addr = A_STATUS; #1;
    check_eq("rst_status", bus.read_data, 32'd0);
    bus.data_addr = A_CYCLE; #1;
    check_eq("cycle5", bus.read_data, 32'd5);
    bus.data_addr = A_TX; #1;
    check_eq("txdata_rd0", bus.read_data, 32'd0);

    // Fill the RAM so every later RAM read has a known value
    for (int i = 0; i < WORDS; i++) wr(32'(i * 4), $urandom);

    wr(32'h0000_0010, 32'hDEAD_BEEF);
    bus.data_addr = 32'h0000_0010; #1;
    check_eq("ram_10", bus.read_data, 32'hDEAD_BEEF);
    bus.data_addr = 32'h0000_0013; #1;
    check_eq("ram_13", bus.read_data, 32'hDEAD_BEEF);
    bus.data_addr = 32'h0000_0400; #1;
    check_eq("ram_oob", bus.read_data, 32'd0);
    rd(32'h0000_0400);

    wr(A_GPIO, 32'h0000_01A5);
    check_eq("gpio_a5", {24'd0, gpio_out}, 32'h0000_00A5);
    bus.data_addr = A_GPIO; #1;
    check_eq("gpio_rd", bus.read_data, 32'h0000_00A5);
    wr(A_CYCLE, 32'h1234_5678);

    // Frame 0x55 with a dropped 0xFF mid-frame, then back-to-back 0xFF
    wr(A_TX, 32'h0000_0055);
    check_eq("start_bit", {31'd0, uart_tx}, 32'd0);
    repeat (8) rd(A_STATUS);
    wr(A_TX, 32'h0000_00FF);
    bus.data_addr = A_STATUS;
    for (int i = 0; i < 60 && m_busy(); i++) tick();
    check_eq("status_idle", bus.read_data, 32'd0);
    wr(A_TX, 32'h0000_00FF);
    check_eq("rearm_start", {31'd0, uart_tx}, 32'd0);
    bus.data_addr = A_STATUS;
    repeat (4) tick();
    check_eq("ff_bit0", {31'd0, uart_tx}, 32'd1);
    repeat (36) tick();
    check_eq("ff_done", bus.read_data, 32'd0);

    // Reset in the middle of data bit 3
    wr(A_GPIO, 32'h0000_003C);
    wr(A_TX, 32'h0000_00F7);
    bus.data_addr = A_STATUS;
    while ((cyc - f_start) < 32'(4 * CPB + 1)) tick();
    #2 reset = 1'b1;
    #1;
    check_eq("mid_rst_tx", {31'd0, uart_tx}, 32'd1);
    check_eq("mid_rst_busy", bus.read_data, 32'd0);
    check_eq("mid_rst_gpio", {24'd0, gpio_out}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    wr(A_TX, 32'h0000_000F);
    bus.data_addr = A_STATUS;
    repeat (42) tick();

    // Random traffic mix across all targets
    for (int n = 0; n < 600; n++) begin
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2: wr(32'($urandom_range(0, WORDS - 1) * 4) | 32'($urandom_range(0, 3)), $urandom);
        3, 4:    rd(32'($urandom_range(0, WORDS * 4 - 1)));
        5: begin
          a = ($urandom_range(0, 1) == 0) ? 32'h0000_0400 + 32'($urandom_range(0, 255))
                                         : 32'h1000_0010 + 32'($urandom_range(0, 255));
          if ($urandom_range(0, 1) == 0) wr(a, $urandom); else rd(a);
        end
        6: wr(A_GPIO, $urandom);
        7: wr(A_TX, $urandom);
        8: rd(A_STATUS);
        default: rd(($urandom_range(0, 1) == 0) ? A_CYCLE : A_GPIO);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
